// File: rtl/hpm_overflow_ctrl_pkg.sv
// hpm_overflow_ctrl_pkg
//   Shared definitions for the HPM overflow / LCOFI controller.
//   - cva6_cfg_t / cva6_cfg_empty: minimal core configuration (XLEN, VLEN).
//   - NUM_COUNTERS_DEFAULT: default number of generic counters (mhpmcounter3..).
//   - MHPMEVENT_OF_BIT: position of the OF bit inside mhpmevent.
//   - lcof_state_e: LCOFI pending state encoding.
package hpm_overflow_ctrl_pkg;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned VLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 64, VLEN: 64};

  localparam int unsigned NUM_COUNTERS_DEFAULT = 6;
  localparam int unsigned MHPMEVENT_OF_BIT     = 63;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } lcof_state_e;

endpackage

// File: rtl/hpm_overflow_ctrl_pc_sampler.sv
// hpm_pc_sampler
//   Captures the commit PC associated with an LCOFI request. If a commit is
//   valid in the request cycle it is captured at the next edge; otherwise the
//   sampler arms and takes the next valid commit PC. A capture is held (not
//   overwritten by later requests) until the pending interrupt clears, which
//   drops valid_o.
// Ports:
//   clk_i, rst_ni     clock, async active-low reset
//   req_i             LCOFI request this cycle
//   pend_d_i          next-state of the LCOFI pending bit
//   commit_pc_i       PC of oldest committing instruction
//   commit_valid_i    commit_pc_i valid
//   pc_o, valid_o     captured PC and its valid flag
module hpm_pc_sampler #(
  parameter int unsigned VLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  input  logic            pend_d_i,
  input  logic [VLEN-1:0] commit_pc_i,
  input  logic            commit_valid_i,
  output logic [VLEN-1:0] pc_o,
  output logic            valid_o
);

  logic [VLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            armed_q, armed_d;

  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    armed_d = armed_q;
    if (!pend_d_i) begin
      // Pending bit clearing releases the capture. A request always keeps
      // pend_d_i high, so this branch never drops a fresh request.
      valid_d = 1'b0;
      armed_d = 1'b0;
    end else if (!valid_q) begin
      if ((req_i || armed_q) && commit_valid_i) begin
        pc_d    = commit_pc_i;
        valid_d = 1'b1;
        armed_d = 1'b0;
      end else if (req_i) begin
        armed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= '0;
      valid_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      armed_q <= armed_d;
    end
  end

  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/hpm_overflow_ctrl.sv
// hpm_overflow_ctrl
//   Sscofpmf counter-overflow controller. Detects the 64-bit wrap of each
//   generic counter, keeps the sticky OF bits, drives scountovf and the
//   LCOFI pending bit.
//   Optional feature macro: HPM_OVF_SAMPLE_PC_EN -- captures the commit PC
//   on an LCOFI request; without it sample_pc_o / sample_valid_o are 0.
// Ports:
//   clk_i, rst_ni               clock, async active-low reset
//   debug_mode_i                suppresses overflow detection
//   cnt_i, inc_i                counter values and increment strobes
//   of_we_i, of_wdata_i         software write of mhpmevent OF bits
//   lcofip_we_i, lcofip_wdata_i software write of mip.LCOFIP
//   commit_pc_i, commit_valid_i commit PC for sampling
//   of_o, scountovf_o           sticky OF bits, scountovf view (bit 3+i)
//   lcofip_o                    LCOFI pending
//   sample_pc_o, sample_valid_o sampled PC (macro only)
module hpm_overflow_ctrl
  import hpm_overflow_ctrl_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg     = cva6_cfg_empty,
  parameter int unsigned NumCounters = NUM_COUNTERS_DEFAULT
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                debug_mode_i,
  input  logic [NumCounters-1:0][63:0]        cnt_i,
  input  logic [NumCounters-1:0]              inc_i,
  input  logic [NumCounters-1:0]              of_we_i,
  input  logic [NumCounters-1:0]              of_wdata_i,
  input  logic                                lcofip_we_i,
  input  logic                                lcofip_wdata_i,
  input  logic [CVA6Cfg.VLEN-1:0]             commit_pc_i,
  input  logic                                commit_valid_i,
  output logic [NumCounters-1:0]              of_o,
  output logic [31:0]                         scountovf_o,
  output logic                                lcofip_o,
  output logic [CVA6Cfg.VLEN-1:0]             sample_pc_o,
  output logic                                sample_valid_o
);

  localparam logic [0:0] ST_IDLE    = IDLE;
  localparam logic [0:0] ST_PENDING = PENDING;

  logic [NumCounters-1:0] ovf;
  logic [NumCounters-1:0] of_q, of_d;
  logic [0:0]             state_q, state_d;
  logic                   lcof_req;

  // Overflow is always the full 64-bit wrap, independent of XLEN.
  for (genvar g = 0; g < NumCounters; g++) begin : g_ovf
    assign ovf[g] = ~debug_mode_i & inc_i[g] & (&cnt_i[g]);
  end

  // Only a counter whose OF was clear produces a new interrupt.
  assign lcof_req = |(ovf & ~of_q);

  // Hardware set beats a same-cycle software write.
  assign of_d = ovf | (of_we_i & of_wdata_i) | (~of_we_i & of_q);

  always_comb begin
    state_d = state_q;
    if (lcofip_we_i) state_d = lcofip_wdata_i ? ST_PENDING : ST_IDLE;
    if (lcof_req)    state_d = ST_PENDING;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      of_q    <= '0;
      state_q <= ST_IDLE;
    end else begin
      of_q    <= of_d;
      state_q <= state_d;
    end
  end

  assign of_o     = of_q;
  assign lcofip_o = (state_q == ST_PENDING);

  always_comb begin
    scountovf_o                  = '0;
    scountovf_o[3 +: NumCounters] = of_q;
  end

`ifdef HPM_OVF_SAMPLE_PC_EN
  hpm_pc_sampler #(
    .VLEN(CVA6Cfg.VLEN)
  ) u_sampler (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (lcof_req),
    .pend_d_i       (state_d == ST_PENDING),
    .commit_pc_i    (commit_pc_i),
    .commit_valid_i (commit_valid_i),
    .pc_o           (sample_pc_o),
    .valid_o        (sample_valid_o)
  );
`else
  logic unused_commit;
  assign unused_commit  = ^{commit_pc_i, commit_valid_i};
  assign sample_pc_o    = '0;
  assign sample_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_hpm_overflow_ctrl.sv
module tb_hpm_overflow_ctrl;
  localparam int N  = 6;
  localparam int VL = 64;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               dbg;
  logic [N-1:0][63:0] cnt;
  logic [N-1:0]       inc, of_we, of_wd;
  logic               lc_we, lc_wd;
  logic [VL-1:0]      cpc;
  logic               cval;
  logic [N-1:0]       of_o;
  logic [31:0]        scov;
  logic               lc_o;
  logic [VL-1:0]      spc;
  logic               sval;

  int errs   = 0;
  int checks = 0;

  hpm_overflow_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .debug_mode_i   (dbg),
    .cnt_i          (cnt),
    .inc_i          (inc),
    .of_we_i        (of_we),
    .of_wdata_i     (of_wd),
    .lcofip_we_i    (lc_we),
    .lcofip_wdata_i (lc_wd),
    .commit_pc_i    (cpc),
    .commit_valid_i (cval),
    .of_o           (of_o),
    .scountovf_o    (scov),
    .lcofip_o       (lc_o),
    .sample_pc_o    (spc),
    .sample_valid_o (sval)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] inc;
    logic [N-1:0] full;
    logic [N-1:0] owe;
    logic [N-1:0] owd;
    logic         dbg;
    logic         lwe;
    logic         lwd;
    logic [N-1:0] e_of;
    logic         e_lc;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counters flagged in 'full' sit at all-ones; others get a value that can never wrap.
  task automatic set_cnt(input logic [N-1:0] full);
    for (int i = 0; i < N; i++)
      cnt[i] = full[i] ? 64'hFFFF_FFFF_FFFF_FFFF : ({$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFE);
  endtask

  task automatic idle();
    inc = '0; of_we = '0; of_wd = '0; lc_we = 1'b0; lc_wd = 1'b0; dbg = 1'b0;
    cval = 1'b0; cpc = '0;
    set_cnt('0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string name, input logic [N-1:0] e_of, input logic e_lc);
    logic [31:0] e_sc;
    e_sc = 32'(e_of) << 3;
    chk({name, ".of"}, 64'(of_o), 64'(e_of));
    chk({name, ".lc"}, 64'(lc_o), 64'(e_lc));
    chk({name, ".scountovf"}, 64'(scov), 64'(e_sc));
  endtask

  // Reference state for random phase: OF bits and pending flag.
  logic [N-1:0] m_of;
  logic         m_p;

  initial begin
    // Table: applied in order from reset, each for one cycle.
    //            inc       full      owe       owd       dbg  lwe  lwd  e_of      e_lc
    tbl[0]  = '{6'b000001, 6'b000001, 6'b000000, 6'b000000, 0, 0, 0, 6'b000001, 1}; // wrap
    tbl[1]  = '{6'b111111, 6'b000000, 6'b000000, 6'b000000, 0, 0, 0, 6'b000001, 1}; // inc, no wrap
    tbl[2]  = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 0, 1, 0, 6'b000001, 0}; // clear lcofip
    tbl[3]  = '{6'b000000, 6'b000000, 6'b000001, 6'b000000, 0, 0, 0, 6'b000000, 0}; // sw clear OF
    tbl[4]  = '{6'b101001, 6'b101001, 6'b000000, 6'b000000, 0, 0, 0, 6'b101001, 1}; // multi wrap
    tbl[5]  = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 0, 1, 0, 6'b101001, 0};
    tbl[6]  = '{6'b000000, 6'b000000, 6'b000100, 6'b000100, 0, 0, 0, 6'b101101, 0}; // sw set OF2
    tbl[7]  = '{6'b000100, 6'b000100, 6'b000000, 6'b000000, 0, 0, 0, 6'b101101, 0}; // wrap, OF set
    tbl[8]  = '{6'b000010, 6'b000010, 6'b000010, 6'b000000, 0, 1, 0, 6'b101111, 1}; // collisions
    tbl[9]  = '{6'b000000, 6'b000000, 6'b111111, 6'b000000, 0, 1, 0, 6'b000000, 0};
    tbl[10] = '{6'b111111, 6'b111111, 6'b000000, 6'b000000, 1, 0, 0, 6'b000000, 0}; // debug
    tbl[11] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 0, 1, 1, 6'b000000, 1}; // sw set lcofip
    tbl[12] = '{6'b010000, 6'b010000, 6'b010000, 6'b010000, 0, 0, 0, 6'b010000, 1};

    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", '0, 1'b0);
    chk("reset.spc", spc, '0);
    chk("reset.sval", 64'(sval), 64'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 13; v++) begin
      inc = tbl[v].inc; of_we = tbl[v].owe; of_wd = tbl[v].owd;
      dbg = tbl[v].dbg; lc_we = tbl[v].lwe; lc_wd = tbl[v].lwd;
      set_cnt(tbl[v].full);
      tick();
      chk_outs($sformatf("vec%0d", v), tbl[v].e_of, tbl[v].e_lc);
      idle();
    end

    // Hold: a quiet cycle keeps state.
    tick();
    chk_outs("hold", 6'b010000, 1'b1);

    // Asynchronous reset while pending clears outputs without a clock edge.
    rst_n = 1'b0;
    #1;
    chk_outs("async_rst", '0, 1'b0);
    #2;
    rst_n = 1'b1;

`ifdef HPM_OVF_SAMPLE_PC_EN
    // Wrap with no commit: sampler arms.
    inc = 6'b000001; set_cnt(6'b000001);
    tick(); idle();
    chk_outs("smp.wrap", 6'b000001, 1'b1);
    chk("smp.armed_sval", 64'(sval), 64'd0);
    tick();
    chk("smp.wait_sval", 64'(sval), 64'd0);
    cval = 1'b1; cpc = 64'h8000_1000;
    tick(); idle();
    chk("smp.pc", spc, 64'h8000_1000);
    chk("smp.sval", 64'(sval), 64'd1);
    // Second request with a valid commit must not overwrite.
    inc = 6'b000010; set_cnt(6'b000010); cval = 1'b1; cpc = 64'h1234;
    tick(); idle();
    chk("smp.hold_pc", spc, 64'h8000_1000);
    chk("smp.hold_sval", 64'(sval), 64'd1);
    lc_we = 1'b1;
    tick(); idle();
    chk("smp.clr_lc", 64'(lc_o), 64'd0);
    chk("smp.clr_sval", 64'(sval), 64'd0);
    // Direct capture when commit is valid in the request cycle.
    inc = 6'b000100; set_cnt(6'b000100); cval = 1'b1; cpc = 64'h2000;
    tick(); idle();
    chk("smp.direct_pc", spc, 64'h2000);
    chk("smp.direct_sval", 64'(sval), 64'd1);
    rst_n = 1'b0; #1; rst_n = 1'b1;
`endif

    // Randomized phase against the reference model.
    m_of = '0;
    m_p  = 1'b0;
    for (int it = 0; it < 400; it++) begin
      logic         newirq;
      logic [N-1:0] full;
      full  = N'($urandom) & N'($urandom);
      inc   = N'($urandom);
      dbg   = ($urandom_range(0, 7) == 0);
      of_we = N'($urandom) & N'($urandom) & N'($urandom);
      of_wd = N'($urandom);
      lc_we = ($urandom_range(0, 3) == 0);
      lc_wd = $urandom_range(0, 1) == 1;
      cval  = $urandom_range(0, 1) == 1;
      cpc   = {$urandom, $urandom};
      set_cnt(full);
      newirq = 1'b0;
      for (int i = 0; i < N; i++) begin
        logic w;
        w = !dbg && inc[i] && full[i];
        if (w && !m_of[i]) newirq = 1'b1;
        if (w)             m_of[i] = 1'b1;
        else if (of_we[i]) m_of[i] = of_wd[i];
      end
      if (newirq)     m_p = 1'b1;
      else if (lc_we) m_p = lc_wd;
      tick();
      chk_outs($sformatf("rnd%0d", it), m_of, m_p);
`ifndef HPM_OVF_SAMPLE_PC_EN
      chk($sformatf("rnd%0d.sval_tied", it), 64'(sval), 64'd0);
      chk($sformatf("rnd%0d.spc_tied", it), spc, '0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
